// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants, board baud defaults and scheduler state encoding
package uart_pkg;

    localparam int UART_DATA_BITS  = 8;
    localparam int UART_FRAME_BITS = 10;

    localparam int CLKS_PER_BIT_25M_115200  = 217;
    localparam int CLKS_PER_BIT_50M_115200  = 434;
    localparam int CLKS_PER_BIT_100M_115200 = 868;

    typedef enum logic [2:0] {
        ARB,
        LOCKED,
        START,
        DATA,
        STOP
    } uart_state_e;

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - clearable per-bit baud counter with end-of-bit tick
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt;

    assign tick = en && (cnt == LAST_CNT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr || tick) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// rtl/uart_tx_sched.sv - round-robin packet-locked scheduler driving one 8N1 UART TX line
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int NREQ         = 4,
    parameter int ID_W         = 2,
    parameter int CLKS_PER_BIT = 434,
    parameter int LOCK_TIMEOUT = 4096
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [8*NREQ-1:0] req_data,
    input  logic [NREQ-1:0]   req_last,
    output logic [NREQ-1:0]   req_ready,
    output logic              tx,
    output logic              busy,
    output logic              grant_valid,
    output logic [ID_W-1:0]   grant_id
);

    localparam int TO_W = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_MAX = TO_W'(LOCK_TIMEOUT - 1);
    localparam logic [2:0] LAST_BIT = 3'(UART_DATA_BITS - 1);

    uart_state_e               state;
    logic [ID_W-1:0]           rr_ptr;
    logic [UART_DATA_BITS-1:0] data_q;
    logic                      last_q;
    logic [2:0]                bit_cnt;
    logic [TO_W-1:0]           to_cnt;

    logic                      accept;
    logic [ID_W-1:0]           acc_id;
    logic [UART_DATA_BITS-1:0] acc_data;
    logic                      acc_last;
    logic [ID_W:0]             ff_hit;
    logic [ID_W-1:0]           next_ptr;
    logic                      baud_en;
    logic                      tick;

    // Returns {hit, index} of the first valid at or after ptr, wrapping modulo NREQ.
    function automatic logic [ID_W:0] rr_find_first(input logic [NREQ-1:0] valid,
                                                    input logic [ID_W-1:0] ptr);
        logic [ID_W:0] res;
        int            idx;
        res = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!res[ID_W] && valid[idx]) res = {1'b1, ID_W'(idx)};
        end
        return res;
    endfunction

    // Ready is gated by rst_n so no requester sees an accept while reset is held.
    always_comb begin
        ff_hit    = rr_find_first(req_valid, rr_ptr);
        accept    = 1'b0;
        acc_id    = grant_id;
        req_ready = '0;
        if (rst_n) begin
            if (state == ARB && ff_hit[ID_W]) begin
                accept = 1'b1;
                acc_id = ff_hit[ID_W-1:0];
            end else if (state == LOCKED && req_valid[grant_id]) begin
                accept = 1'b1;
                acc_id = grant_id;
            end
        end
        if (accept) req_ready[acc_id] = 1'b1;
    end

    always_comb begin
        acc_data = '0;
        acc_last = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (acc_id == ID_W'(i)) begin
                acc_data = req_data[8*i +: 8];
                acc_last = req_last[i];
            end
        end
    end

    assign next_ptr = (grant_id == ID_W'(NREQ - 1)) ? '0 : grant_id + 1'b1;
    assign baud_en  = (state == START) || (state == DATA) || (state == STOP);
    assign busy     = (state != ARB);

    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (accept),
        .en    (baud_en),
        .tick  (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ARB;
            tx          <= 1'b1;
            grant_valid <= 1'b0;
            grant_id    <= '0;
            rr_ptr      <= '0;
            data_q      <= '0;
            last_q      <= 1'b0;
            bit_cnt     <= '0;
            to_cnt      <= '0;
        end else begin
            case (state)
                ARB, LOCKED: begin
                    if (accept) begin
                        data_q      <= acc_data;
                        last_q      <= acc_last;
                        grant_id    <= acc_id;
                        grant_valid <= 1'b1;
                        to_cnt      <= '0;
                        bit_cnt     <= '0;
                        tx          <= 1'b0;
                        state       <= START;
                    end else if (state == LOCKED) begin
                        if (to_cnt == TO_MAX) begin
                            grant_valid <= 1'b0;
                            rr_ptr      <= next_ptr;
                            state       <= ARB;
                        end else begin
                            to_cnt <= to_cnt + 1'b1;
                        end
                    end
                end
                START: begin
                    if (tick) begin
                        tx    <= data_q[0];
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (bit_cnt == LAST_BIT) begin
                            tx    <= 1'b1;
                            state <= STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                            tx      <= data_q[bit_cnt + 3'd1];
                        end
                    end
                end
                STOP: begin
                    if (tick) begin
                        to_cnt <= '0;
                        if (last_q) begin
                            grant_valid <= 1'b0;
                            rr_ptr      <= next_ptr;
                            state       <= ARB;
                        end else begin
                            state <= LOCKED;
                        end
                    end
                end
                default: begin
                    tx    <= 1'b1;
                    state <= ARB;
                end
            endcase
        end
    end

endmodule
